// File: rtl/slip_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : slip_bus_arbiter
// Purpose  : Four-way Slipstream bus arbiter with turnaround cycle and burst
//            limit. Define ARB_ROUND_ROBIN_EN for round-robin among 1..3.
// Revision : 1.0 - initial release
// ============================================================================
module slip_bus_arbiter #(
  parameter int unsigned MAXBURST = 8
) (
  input  logic       MasterClock,
  input  logic       RESET,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic       BUSEN,
  output logic [1:0] OWNER,
  output logic       BUSY
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_OWN   = 2'd2;

  localparam logic [7:0] BURST_RELOAD = 8'(MAXBURST - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic       busen_q, busen_d;
  logic [1:0] owner_q, owner_d;
  logic       busy_q, busy_d;
  logic [7:0] cnt_q, cnt_d;

  logic [3:0] cand;
  logic       win_any;
  logic [1:0] win_idx;
  logic       release_bus;

  // The current owner never competes on its own release edge.
  assign cand    = (state_q == ST_OWN) ? (REQ & ~gnt_q) : REQ;
  assign win_any = |cand;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  function automatic logic [1:0] rr_pick(input logic [3:0] c, input logic [1:0] p);
    logic [1:0] a, b, d;
    case (p)
      2'd2:    {a, b, d} = {2'd2, 2'd3, 2'd1};
      2'd3:    {a, b, d} = {2'd3, 2'd1, 2'd2};
      default: {a, b, d} = {2'd1, 2'd2, 2'd3};
    endcase
    if (c[0])      return 2'd0;
    else if (c[a]) return a;
    else if (c[b]) return b;
    else if (c[d]) return d;
    else           return 2'd0;
  endfunction

  assign win_idx = rr_pick(cand, ptr_q);

  // Entering GRANT from any other state is exactly a new grant.
  always_comb begin
    ptr_d = ptr_q;
    if (state_d == ST_GRANT && state_q != ST_GRANT && win_idx != 2'd0)
      ptr_d = (win_idx == 2'd3) ? 2'd1 : win_idx + 2'd1;
  end

  always_ff @(posedge MasterClock or posedge RESET) begin
    if (RESET) ptr_q <= 2'd1;
    else       ptr_q <= ptr_d;
  end
`else
  function automatic logic [1:0] fixed_pick(input logic [3:0] c);
    if (c[0])      return 2'd0;
    else if (c[1]) return 2'd1;
    else if (c[2]) return 2'd2;
    else if (c[3]) return 2'd3;
    else           return 2'd0;
  endfunction

  assign win_idx = fixed_pick(cand);
`endif

  assign release_bus = !REQ[owner_q] || (cnt_q == 8'd0 && win_any);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    busen_d = busen_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          state_d = ST_GRANT;
          gnt_d   = 4'(1) << win_idx;
          owner_d = win_idx;
          busy_d  = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!REQ[owner_q]) begin
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
          owner_d = 2'd0;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_OWN;
          busen_d = 1'b1;
          cnt_d   = BURST_RELOAD;
        end
      end
      ST_OWN: begin
        if (release_bus) begin
          busen_d = 1'b0;
          if (win_any) begin
            state_d = ST_GRANT;
            gnt_d   = 4'(1) << win_idx;
            owner_d = win_idx;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            owner_d = 2'd0;
            busy_d  = 1'b0;
          end
        end else if (cnt_q == 8'd0) begin
          cnt_d = BURST_RELOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        busen_d = 1'b0;
        owner_d = 2'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge MasterClock or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'b0000;
      busen_q <= 1'b0;
      owner_q <= 2'd0;
      busy_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busen_q <= busen_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign GNT   = gnt_q;
  assign BUSEN = busen_q;
  assign OWNER = owner_q;
  assign BUSY  = busy_q;

endmodule
`default_nettype wire

// File: doc/slip_bus_arbiter.md
# slip_bus_arbiter

Four-way arbiter sharing the Slipstream buffered memory bus between the video fetch, blitter, DSP and CPU requesters. It grants one requester at a time, drives the bus buffer enable, and enforces a turnaround cycle and a maximum burst length so no requester starves the others. It sits between the requester state machines and the buffered bus drivers, and sequences their enables.

## Interface
- MAXBURST, 8: maximum consecutive OWN cycles per grant when another requester is waiting; legal range 1..255.
- MasterClock  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- REQ  input  4  request lines: bit 0 video (highest), bit 1 blitter, bit 2 DSP, bit 3 CPU. A requester holds its bit until it has finished with the bus.
- GNT  output  4  one-hot grant, or all zero. Registered.
- BUSEN  output  1  bus buffer drive enable for the current owner. Registered.
- OWNER  output  2  encoded index of the granted requester; 0 when GNT is zero.
- BUSY  output  1  high in GRANT and OWN.

## Operation
- Reset values: GNT=0000, BUSEN=0, OWNER=0, BUSY=0, state IDLE, burst counter=0, round-robin pointer=1.
- States:
  - IDLE: no grant.
  - GRANT: turnaround cycle; GNT is valid and BUSEN=0.
  - OWN: GNT and BUSEN are both valid.
- IDLE -> GRANT when any REQ bit is set. The winner is latched into GNT and OWNER.
- GRANT -> OWN unconditionally. BUSEN goes to 1 and the burst counter loads MAXBURST-1.
- GRANT -> IDLE instead, if REQ[owner] has dropped during GRANT. GNT is cleared.
- In OWN, on each edge:
  - If REQ[owner]=0, release the bus.
  - Otherwise, if the counter is 0 and some other REQ bit is set, release the bus (burst expiry).
  - Otherwise, if the counter is 0 and no other REQ bit is set, reload the counter to MAXBURST-1 and stay in OWN.
  - Otherwise, decrement the counter and stay in OWN.
- Release: BUSEN and GNT clear on the same edge.
  - If any other REQ bit is set, go directly to GRANT with the new winner. Its turnaround cycle still occurs.
  - If no other REQ bit is set, go to IDLE.
- The releasing requester is excluded from arbitration on the release edge only.
- Winner selection uses REQ as sampled at the deciding edge. Selection is combinational from REQ, the state and the round-robin pointer.
- The counter is 8 bits. With MAXBURST=1 the counter loads 0, so expiry is possible after a single OWN cycle.
- GNT is never non-zero for two different requesters on the same cycle. BUSEN=1 implies exactly one GNT bit is set.

## Timing
- Request to grant: REQ set before edge N gives GNT at N, BUSEN at N+1. Bus latency is 2 cycles from IDLE.
- Release to next grant: REQ[owner] dropped before edge M gives BUSEN=0 at M, with the next GNT also at M, and next BUSEN at M+1.
- Burst expiry: when another requester is waiting, an owner keeps BUSEN for exactly MAXBURST cycles.
- Simultaneous requests in IDLE are resolved by the selection rule in Configuration.
- REQ[owner] dropping and burst expiry on the same edge are treated as a release. The outcome is the same either way.
- RESET asserted mid-burst clears all outputs immediately (asynchronously), with no turnaround or release cycle. After RESET falls, arbitration restarts from IDLE at the next edge.

## Configuration
- ARB_ROUND_ROBIN_EN undefined: fixed priority. The lowest set REQ index wins. The round-robin pointer is not implemented.
- ARB_ROUND_ROBIN_EN defined: video (bit 0) still wins whenever REQ[0] is set.
  - Among bits 1..3, the search starts at the pointer and wraps 3 -> 1.
  - On every grant to requester k in 1..3, the pointer becomes k+1, wrapping 4 -> 1.
  - Grants to video do not move the pointer.

## Test plan
- Reset: hold RESET with REQ=1111 -> GNT=0000, BUSEN=0, OWNER=0, BUSY=0.
- Single request: REQ=0100 from IDLE at edge 0 -> GNT=0100 and OWNER=2 at edge 0, BUSEN=1 at edge 1. Drop REQ -> GNT=0, BUSEN=0, state IDLE the next edge.
- Burst expiry, MAXBURST=4: CPU owns the bus, then blitter requests -> CPU BUSEN high for exactly 4 cycles, 1 turnaround cycle with GNT=0010 and BUSEN=0, then blitter BUSEN=1.
- Priority, macro undefined: REQ=1110 held, each requester dropping its bit after 2 OWN cycles -> grants in order 0010, 0100, 1000.
- Round-robin, macro defined: REQ=1110 held with MAXBURST=2 -> grants cycle 0010, 0100, 1000, 0010. Asserting REQ[0] then preempts at the next burst expiry with GNT=0001.
- Async reset mid-OWN: assert RESET between edges while BUSEN=1 -> BUSEN and GNT fall before the next edge. After release, with REQ=0001, GNT=0001 at the first edge.
